// File: rtl/collision_detect_if.sv
// Tile ROM bus between collision_detect and the level map.
interface collision_detect_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] tile_addr;
  logic [1:0]        tile_type;

  modport master (
    output tile_addr,
    input  tile_type
  );

  modport slave (
    input  tile_addr,
    output tile_type
  );
endinterface

// File: rtl/collision_detect.sv
// Eight-point edge probe of the player hitbox against the tile map.
// Optional spike contact flag enabled by `define SPIKE_DETECT_EN.
module collision_detect #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 25,
  parameter int MAP_ROWS   = 19,
  parameter int PLAYER_W   = 20,
  parameter int PLAYER_H   = 20,
  parameter int ADDR_W     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  collision_detect_if.master rom,
  output logic [3:0] is_collide,
  output logic       collide_valid,
  output logic       dead
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [9:0]        sx_q, sx_d;
  logic [9:0]        sy_q, sy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        oob_q, oob_d;
  logic [3:0]        acc_q, acc_d;
  logic [3:0]        coll_q, coll_d;
  logic              spk_q, spk_d;
  logic              dead_q, dead_d;
  logic              vld_q, vld_d;

  logic [2:0]        pk;
  logic [9:0]        bx, by;
  logic signed [10:0] dx, dy, px, py;
  logic [9:0]        col, row;
  logic [15:0]       lin;
  logic              oob;
  logic [ADDR_W-1:0] paddr;

  // Address of the probe that goes on the bus at the next edge
  always_comb begin
    pk = (state_q == IDLE) ? 3'd0 : k_q + 3'd1;
    bx = (state_q == IDLE) ? pos_x : sx_q;
    by = (state_q == IDLE) ? pos_y : sy_q;
    dx = '0;
    dy = '0;
    unique case (pk)
      3'd0: dy = -11'sd1;
      3'd1: begin
        dx = 11'(PLAYER_W - 1);
        dy = -11'sd1;
      end
      3'd2: dy = 11'(PLAYER_H);
      3'd3: begin
        dx = 11'(PLAYER_W - 1);
        dy = 11'(PLAYER_H);
      end
      3'd4: dx = -11'sd1;
      3'd5: begin
        dx = -11'sd1;
        dy = 11'(PLAYER_H - 1);
      end
      3'd6: dx = 11'(PLAYER_W);
      3'd7: begin
        dx = 11'(PLAYER_W);
        dy = 11'(PLAYER_H - 1);
      end
    endcase
    px  = $signed({1'b0, bx}) + dx;
    py  = $signed({1'b0, by}) + dy;
    col = px[9:0] >> TILE_SHIFT;
    row = py[9:0] >> TILE_SHIFT;
    oob = px[10] | py[10]
        | (px[9:0] >= 10'(SCREEN_W))
        | (py[9:0] >= 10'(SCREEN_H))
        | (col >= 10'(MAP_COLS))
        | (row >= 10'(MAP_ROWS));
    lin   = 16'(row) * 16'(MAP_COLS) + 16'(col);
    paddr = oob ? '0 : lin[ADDR_W-1:0];
  end

  logic       eval_en;
  logic [2:0] eval_idx;
  logic [1:0] side;
  logic       hit;
  logic [3:0] acc_f;
  logic       spk_f;

  // ROM data arriving now belongs to the previous slot
  always_comb begin
    eval_en  = ((state_q == PROBE) && (k_q != 3'd0))
             || (state_q == DRAIN);
    eval_idx = (state_q == DRAIN) ? 3'd7 : k_q - 3'd1;
    side     = 2'd3 - eval_idx[2:1];
    hit      = oob_q[eval_idx] | rom.tile_type[0];
    acc_f    = acc_q;
    if (eval_en) acc_f[side] = acc_f[side] | hit;
`ifdef SPIKE_DETECT_EN
    spk_f = spk_q | (eval_en & ~oob_q[eval_idx]
          & (rom.tile_type == 2'b10));
`else
    spk_f = 1'b0;
`endif
  end

`ifndef SPIKE_DETECT_EN
  logic unused_spike;
  assign unused_spike = rom.tile_type[1] | spk_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    addr_d  = addr_q;
    oob_d   = oob_q;
    acc_d   = acc_f;
    spk_d   = spk_f;
    coll_d  = coll_q;
    dead_d  = dead_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sx_d     = pos_x;
        sy_d     = pos_y;
        acc_d    = '0;
        spk_d    = 1'b0;
        k_d      = '0;
        addr_d   = paddr;
        oob_d[0] = oob;
        state_d  = PROBE;
      end
      PROBE: begin
        if (k_q == 3'd7) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          k_d       = k_q + 3'd1;
          addr_d    = paddr;
          oob_d[pk] = oob;
        end
      end
      DRAIN: begin
        coll_d  = acc_f;
        dead_d  = dead_q | spk_f;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      addr_q  <= '0;
      oob_q   <= '0;
      acc_q   <= '0;
      spk_q   <= 1'b0;
      coll_q  <= '0;
      dead_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      addr_q  <= addr_d;
      oob_q   <= oob_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      coll_q  <= coll_d;
      dead_q  <= dead_d;
      vld_q   <= vld_d;
    end
  end

  assign rom.tile_addr  = addr_q;
  assign is_collide     = coll_q;
  assign collide_valid  = vld_q;
  assign dead           = dead_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect with a registered tile ROM model.
module tb_collision_detect;
  logic       clk;
  logic       rst;
  logic [9:0] pos_x, pos_y;
  logic [3:0] is_collide;
  logic       collide_valid;
  logic       dead;
  logic [1:0] mem [0:511];
  int         n_checks;
  int         n_fail;

  collision_detect_if #(.ADDR_W(9)) rom_if ();

  collision_detect dut (
    .clk           (clk),
    .rst           (rst),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .rom           (rom_if.master),
    .is_collide    (is_collide),
    .collide_valid (collide_valid),
    .dead          (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_if.tile_type <= mem[rom_if.tile_addr];

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) mem[i] = 2'b00;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!collide_valid && n < 40);
  endtask

  task automatic settle(output int n);
    int a;
    wait_pulse(a);
    wait_pulse(n);
    if (a >= 40) n = 40;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (is_collide !== 4'b0000) begin
      $display("FAIL reset_coll got %b want 0000", is_collide);
      n_fail++;
    end
    if (collide_valid !== 1'b0) begin
      $display("FAIL reset_vld got %b want 0", collide_valid);
      n_fail++;
    end
    if (rom_if.tile_addr !== 9'd0) begin
      $display("FAIL reset_addr got %0d want 0", rom_if.tile_addr);
      n_fail++;
    end
    if (dead !== 1'b0) begin
      $display("FAIL reset_dead got %b want 0", dead);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_floor();
    int n;
    clear_rom();
    for (int c = 0; c < 25; c++) mem[450 + c] = (c % 2) ? 2'b11 : 2'b01;
    pos_x = 10'd200;
    pos_y = 10'd556;
    settle(n);
    n_checks += 2;
    if (n >= 40) begin
      $display("FAIL floor_timeout got %0d cycles", n);
      n_fail++;
    end
    if (is_collide !== 4'b0100) begin
      $display("FAIL floor_coll got %b want 0100", is_collide);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rom_if.tile_addr !== 9'd431) begin
      $display("FAIL floor_addr_k0 got %0d want 431", rom_if.tile_addr);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rom_if.tile_addr !== 9'd456) begin
      $display("FAIL floor_addr_k2 got %0d want 456", rom_if.tile_addr);
      n_fail++;
    end
  endtask

  task automatic test_screen_edge();
    int n;
    clear_rom();
    pos_x = 10'd0;
    pos_y = 10'd0;
    settle(n);
    n_checks++;
    if (n >= 40 || is_collide !== 4'b1010) begin
      $display("FAIL edge_origin got %b want 1010 (%0d cyc)", is_collide, n);
      n_fail++;
    end
    pos_x = 10'd780;
    pos_y = 10'd580;
    settle(n);
    n_checks++;
    if (n >= 40 || is_collide !== 4'b0101) begin
      $display("FAIL edge_corner got %b want 0101 (%0d cyc)", is_collide, n);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (rom_if.tile_addr !== 9'd474) begin
      $display("FAIL edge_addr_k0 got %0d want 474", rom_if.tile_addr);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rom_if.tile_addr !== 9'd0) begin
      $display("FAIL edge_addr_oob got %0d want 0", rom_if.tile_addr);
      n_fail++;
    end
  endtask

  task automatic test_wall_right();
    int n;
    clear_rom();
    mem[257] = 2'b01;
    pos_x = 10'd204;
    pos_y = 10'd320;
    settle(n);
    n_checks++;
    if (n >= 40 || is_collide !== 4'b0001) begin
      $display("FAIL wall_touch got %b want 0001 (%0d cyc)", is_collide, n);
      n_fail++;
    end
    pos_x = 10'd203;
    settle(n);
    n_checks++;
    if (n >= 40 || is_collide !== 4'b0000) begin
      $display("FAIL wall_gap got %b want 0000 (%0d cyc)", is_collide, n);
      n_fail++;
    end
  endtask

  task automatic test_mid_scan_move();
    int n;
    pos_x = 10'd204;
    settle(n);
    repeat (4) @(negedge clk);
    pos_x = 10'd203;
    n = 4;
    do begin
      @(negedge clk);
      n++;
    end while (!collide_valid && n < 40);
    n_checks += 2;
    if (n !== 10) begin
      $display("FAIL move_spacing1 got %0d want 10", n);
      n_fail++;
    end
    if (is_collide !== 4'b0001) begin
      $display("FAIL move_old got %b want 0001", is_collide);
      n_fail++;
    end
    @(negedge clk);
    n = 1;
    n_checks++;
    if (collide_valid !== 1'b0) begin
      $display("FAIL move_pulse_width got %b want 0", collide_valid);
      n_fail++;
    end
    while (!collide_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks += 2;
    if (n !== 10) begin
      $display("FAIL move_spacing2 got %0d want 10", n);
      n_fail++;
    end
    if (is_collide !== 4'b0000) begin
      $display("FAIL move_new got %b want 0000", is_collide);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    pos_x = 10'd204;
    settle(n);
    n_checks++;
    if (n >= 40 || is_collide !== 4'b0001) begin
      $display("FAIL rstmid_pre got %b want 0001", is_collide);
      n_fail++;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (is_collide !== 4'b0000) begin
      $display("FAIL rstmid_coll got %b want 0000", is_collide);
      n_fail++;
    end
    if (collide_valid !== 1'b0) begin
      $display("FAIL rstmid_vld got %b want 0", collide_valid);
      n_fail++;
    end
    if (rom_if.tile_addr !== 9'd0) begin
      $display("FAIL rstmid_addr got %0d want 0", rom_if.tile_addr);
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_pulse(n);
    n_checks += 2;
    if (n !== 10) begin
      $display("FAIL rstmid_latency got %0d want 10", n);
      n_fail++;
    end
    if (is_collide !== 4'b0001) begin
      $display("FAIL rstmid_commit got %b want 0001", is_collide);
      n_fail++;
    end
  endtask

  task automatic test_spike();
    int  n;
    logic exp_dead;
`ifdef SPIKE_DETECT_EN
    exp_dead = 1'b1;
`else
    exp_dead = 1'b0;
`endif
    clear_rom();
    for (int c = 0; c < 25; c++) mem[450 + c] = 2'b10;
    pos_x = 10'd200;
    pos_y = 10'd556;
    settle(n);
    n_checks += 2;
    if (n >= 40 || is_collide !== 4'b0000) begin
      $display("FAIL spike_coll got %b want 0000", is_collide);
      n_fail++;
    end
    if (dead !== exp_dead) begin
      $display("FAIL spike_dead got %b want %b", dead, exp_dead);
      n_fail++;
    end
    pos_y = 10'd300;
    settle(n);
    n_checks += 2;
    if (n >= 40 || is_collide !== 4'b0000) begin
      $display("FAIL spike_away_coll got %b want 0000", is_collide);
      n_fail++;
    end
    if (dead !== exp_dead) begin
      $display("FAIL spike_sticky got %b want %b", dead, exp_dead);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pos_x    = '0;
    pos_y    = '0;
    clear_rom();
    test_reset();
    test_floor();
    test_screen_edge();
    test_wall_right();
    test_mid_scan_move();
    test_reset_mid_scan();
    test_spike();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
